// File: rtl/fpu_pkg.sv
// Shared types and IEEE-754 special-value helpers for the FPU issue controller.
// Constant functions return 64-bit patterns; callers slice to PRECISION.
package fpu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } issue_state_e;

  function automatic logic [63:0] pinf(input int prec);
    return (prec == 64) ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
  endfunction

  function automatic logic [63:0] ninf(input int prec);
    return (prec == 64) ? 64'hFFF0_0000_0000_0000 : 64'h0000_0000_FF80_0000;
  endfunction

  function automatic logic [63:0] nan(input int prec);
    return (prec == 64) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
  endfunction

endpackage

// File: rtl/fpu_wait_counter.sv
// 16-bit saturating WAIT-cycle counter; cnt_inc is the value including the current cycle.
// at_limit flags that the current cycle is the LIMIT-th one; no backpressure.
module fpu_wait_counter #(
  parameter int LIMIT = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] cnt_inc,
  output logic        at_limit
);

  logic [15:0] count;

  assign cnt_inc  = (count == 16'hFFFF) ? count : count + 16'd1;
  assign at_limit = (cnt_inc >= 16'(LIMIT));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= cnt_inc;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Bridges a tagged valid/ready command stream onto the FPU start/done pins, one op at a time.
// Response follows Done by one cycle; Rsp_* hold until consumed, and commands stall meanwhile.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int PRECISION      = 32,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TAG_W          = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic [1:0]           Cmd_Op,
  input  logic [PRECISION-1:0] Cmd_A,
  input  logic [PRECISION-1:0] Cmd_B,
  input  logic [TAG_W-1:0]     Cmd_Tag,
  output logic [PRECISION-1:0] Fpu_A,
  output logic [PRECISION-1:0] Fpu_B,
  output logic [1:0]           Fpu_Operation,
  output logic                 Fpu_Reset,
  input  logic [PRECISION-1:0] Fpu_Result,
  input  logic                 Fpu_Done,
  output logic                 Rsp_Valid,
  input  logic                 Rsp_Ready,
  output logic [PRECISION-1:0] Rsp_Result,
  output logic [TAG_W-1:0]     Rsp_Tag,
  output logic                 Rsp_Timeout,
  output logic [15:0]          Rsp_Cycles
);

  localparam logic [63:0] NAN_BITS   = nan(PRECISION);
  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);

  issue_state_e       state;
  logic               cmd_ready_q;
  logic [15:0]        start_cnt;
  logic [TAG_W-1:0]   tag_q;
  logic               accept;
  logic [15:0]        cnt_inc;
  logic               at_limit;

  // Gated with the reset pin so the host never sees ready while reset is asserted.
  assign Cmd_Ready = cmd_ready_q & Reset_n;
  assign accept    = Cmd_Valid & Cmd_Ready;

  fpu_wait_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk      (Clk),
    .reset_n  (Reset_n),
    .clear    (accept),
    .enable   (state == ST_WAIT),
    .cnt_inc  (cnt_inc),
    .at_limit (at_limit)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      start_cnt     <= 16'd0;
      tag_q         <= '0;
      Fpu_A         <= '0;
      Fpu_B         <= '0;
      Fpu_Operation <= 2'b00;
      Fpu_Reset     <= 1'b1;
      Rsp_Valid     <= 1'b0;
      Rsp_Result    <= '0;
      Rsp_Tag       <= '0;
      Rsp_Timeout   <= 1'b0;
      Rsp_Cycles    <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          Fpu_Reset <= 1'b1;
          if (accept) begin
            Fpu_A         <= Cmd_A;
            Fpu_B         <= Cmd_B;
            Fpu_Operation <= Cmd_Op;
            tag_q         <= Cmd_Tag;
            start_cnt     <= 16'd0;
            cmd_ready_q   <= 1'b0;
            state         <= ST_START;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_START: begin
          if (start_cnt == START_LAST) begin
            Fpu_Reset <= 1'b0;
            state     <= ST_WAIT;
          end else begin
            start_cnt <= start_cnt + 16'd1;
          end
        end
        ST_WAIT: begin
          // Done takes priority over a timeout landing on the same cycle.
          if (Fpu_Done) begin
            Rsp_Result  <= Fpu_Result;
            Rsp_Timeout <= 1'b0;
            Rsp_Cycles  <= cnt_inc;
            Rsp_Tag     <= tag_q;
            Rsp_Valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (at_limit) begin
            Rsp_Result  <= NAN_BITS[PRECISION-1:0];
            Rsp_Timeout <= 1'b1;
            Rsp_Cycles  <= cnt_inc;
            Rsp_Tag     <= tag_q;
            Rsp_Valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (Rsp_Ready) begin
            Rsp_Valid   <= 1'b0;
            Fpu_Reset   <= 1'b1;
            cmd_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the FPU start/done interface; drives operands, Operation and the active-high Reset (start) pin of FPU, then collects Result on Done.
- Converts that interface into two valid/ready streams: a tagged command stream in, a tagged response stream out.
- Adds cycle measurement and a timeout, so a hung FPU cannot stall the host datapath.
- Sits between the host datapath/sequencer and one FPU instance; one operation outstanding at a time.

Parameters:
- PRECISION, 32, operand/result width (32 or 64).
- START_CYCLES, 2, clock cycles Fpu_Reset is held high with new operands before release; legal range >=1.
- TIMEOUT_CYCLES, 512, WAIT cycles allowed before a timeout response; legal range 1..65535.
- TAG_W, 4, command/response tag width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  one clock; reset is synchronous and active-low.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  command accepted when Cmd_Valid & Cmd_Ready.
- Cmd_Op  in  2  00 add, 01 sub, 10 mul, 11 div.
- Cmd_A  in  PRECISION  operand A.
- Cmd_B  in  PRECISION  operand B.
- Cmd_Tag  in  TAG_W  returned unchanged on the response.
- Fpu_A  out  PRECISION  operand A to FPU.
- Fpu_B  out  PRECISION  operand B to FPU.
- Fpu_Operation  out  2  to FPU Operation.
- Fpu_Reset  out  1  to FPU Reset; high = clear/start.
- Fpu_Result  in  PRECISION  FPU Result.
- Fpu_Done  in  1  FPU Done.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  response consumed when Rsp_Valid & Rsp_Ready.
- Rsp_Result  out  PRECISION  result, or NAN on timeout.
- Rsp_Tag  out  TAG_W  tag of the completed command.
- Rsp_Timeout  out  1  1 = FPU did not raise Done in time.
- Rsp_Cycles  out  16  WAIT cycles up to and including the Done sample; saturates at 0xFFFF.

Behaviour:
Reset
- Reset_n low at a rising edge puts the block in IDLE.
- Reset values: Cmd_Ready=0, Rsp_Valid=0, Fpu_Reset=1, Fpu_A/Fpu_B/Fpu_Operation=0, Rsp_Result=0, Rsp_Tag=0, Rsp_Timeout=0, Rsp_Cycles=0.
- Cmd_Ready is 0 whenever Reset_n is low.

State machine: IDLE, START, WAIT, RESP
- IDLE:
  - Cmd_Ready=1, Fpu_Reset=1.
  - On accept: register Cmd_A/Cmd_B/Cmd_Op into Fpu_A/Fpu_B/Fpu_Operation and the tag internally; clear counter; go to START.
- START:
  - Fpu_Reset=1 for exactly START_CYCLES cycles, with the new operands already on the Fpu_ outputs; then go to WAIT.
- WAIT:
  - Fpu_Reset=0.
  - Each cycle, increment the counter (saturating) and sample Fpu_Done.
  - Fpu_Done=1: Rsp_Result<=Fpu_Result, Rsp_Timeout<=0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES: Rsp_Result<=NAN(PRECISION), Rsp_Timeout<=1, go to RESP.
  - Done and timeout in the same cycle: Done wins.
  - Fpu_Done is guaranteed low on WAIT entry because the FPU was held in reset; no masking is needed.
- RESP:
  - Rsp_Valid=1; Fpu_Reset stays 0, so the FPU output is held.
  - Rsp_* outputs stay stable until the handshake; on handshake go to IDLE.

Rules and boundary conditions
- Fpu_A/Fpu_B/Fpu_Operation are stable from the accept edge until the IDLE re-entry edge.
- Cmd_Ready=0 in START/WAIT/RESP; Cmd_Valid is ignored there.
- Rsp_Valid goes high the cycle after Done is sampled.
- Back-to-back throughput: one command per (1 + START_CYCLES + WAIT + RESP) cycles; at least one IDLE cycle between operations.
- Reset_n low in any state: next edge goes to IDLE with reset values; the in-flight response is discarded and never presented.
- Rsp_Ready held high while not in RESP has no effect.
- All arithmetic is in the FPU; this block never alters operand or result bits, apart from the timeout NAN.

Decomposition:
- Package fpu_pkg:
  - fpu_op_e enum (ADD=00, SUB=01, MUL=10, DIV=11).
  - Constant functions pinf/ninf/nan(PRECISION), bit patterns sign|all-ones exponent|0, and 0|all-ones exponent|all-ones mantissa.
  - Issue-state enum.
- One natural sub-module: fpu_wait_counter, a 16-bit saturating counter with clear/enable and an at-limit compare against TIMEOUT_CYCLES.
- The FSM and registers stay in fpu_issue_ctrl.

Test Plan:
- Bench uses a behavioural FPU model with programmable Done delay and result; PRECISION=32, START_CYCLES=2, TIMEOUT_CYCLES=512.
- Reset: Reset_n low 3 cycles -> Cmd_Ready=0, Rsp_Valid=0, Fpu_Reset=1, Fpu_A=0; first edge with Reset_n high -> Cmd_Ready=1.
- Mul 0x3FC00000 x 0x3FC00000, tag 5; model Done after 40 WAIT cycles with 0x40100000 -> Fpu_Reset high exactly 2 cycles; Rsp_Result=0x40100000, Rsp_Tag=5, Rsp_Cycles=40, Rsp_Timeout=0.
- Backpressure: Rsp_Ready low 10 cycles while Cmd_Valid stays high with a new command -> Rsp_* stable; Cmd_Ready=0; second command accepted only on the IDLE cycle after the handshake.
- Timeout: model never raises Done -> Rsp_Valid after 512 WAIT cycles; Rsp_Result=0x7FFFFFFF, Rsp_Timeout=1, Rsp_Cycles=512.
- Boundary: Done sampled in the 512th WAIT cycle -> Rsp_Timeout=0, Rsp_Result=model result, Rsp_Cycles=512.
- Reset mid-WAIT (cycle 20 of a div) -> IDLE next edge; no Rsp_Valid; Fpu_Reset=1. A following add 0x3F800000+0x3F800000 returns 0x40000000 normally.
